// File: rtl/ddr2_dq_calib_seq.sv
// ddr2_dq_calib_seq: per-DQS-group sequencer for per-bit DQ tap calibration.
// Holds the dummy-read request, muxes one DQ bit to the tap controller,
// routes IDELAY ce to that bit only, and tracks each bit's tap value.
// Optional per-bit watchdog is enabled by defining DDR2_CALIB_TIMEOUT_EN.
module ddr2_dq_calib_seq #(
  parameter int unsigned DQ_WIDTH  = 8,
  parameter int unsigned DQ_SEL_W  = 3,
  parameter int unsigned TIMEOUT_W = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  calib_start,
  input  logic [DQ_WIDTH-1:0]   dq_in,
  output logic                  dq_data,
  output logic                  ctrl_dummyread_start,
  input  logic                  dlyce_in,
  input  logic                  dlyinc_in,
  input  logic                  chan_done_in,
  output logic [DQ_WIDTH-1:0]   dlyce,
  output logic [DQ_WIDTH-1:0]   dlyinc,
  output logic                  idelay_rst,
  output logic [DQ_SEL_W-1:0]   bit_sel,
  output logic [6*DQ_WIDTH-1:0] tap_cnt,
  output logic                  calib_done,
  output logic                  calib_err
);

  typedef enum logic [1:0] {StIdle, StRun, StDone, StErr} state_e;

  state_e              state_q, state_d;
  logic [DQ_SEL_W-1:0] bit_sel_q;
  logic                idelay_rst_q;
  logic [5:0]          tap_q [DQ_WIDTH];
  logic [5:0]          tap_cur, tap_nxt;

  logic run, start_run, last_bit, advance, wd_expired;

  assign run       = (state_q == StRun);
  assign start_run = (state_q == StIdle) && calib_start;
  assign last_bit  = (bit_sel_q == DQ_SEL_W'(DQ_WIDTH - 1));
  // Abort (calib_start low) outranks a coincident chan_done.
  assign advance   = run && calib_start && chan_done_in && !last_bit;

`ifdef DDR2_CALIB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_q;

  // Per-bit watchdog: cleared at run start and on each bit advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else if (start_run || advance) begin
      wd_q <= '0;
    end else if (run) begin
      wd_q <= wd_q + TIMEOUT_W'(1);
    end
  end

  assign wd_expired = &wd_q;
`else
  logic [TIMEOUT_W-1:0] unused_timeout;
  assign unused_timeout = '0;
  assign wd_expired     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (calib_start) state_d = StRun;
      StRun: begin
        if (!calib_start)                 state_d = StIdle;
        else if (chan_done_in && last_bit) state_d = StDone;
        else if (wd_expired && !chan_done_in) state_d = StErr;
      end
      StDone, StErr: if (!calib_start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state, plus combinational routing
  always_comb begin
    ctrl_dummyread_start = run;
    calib_done           = (state_q == StDone);
`ifdef DDR2_CALIB_TIMEOUT_EN
    calib_err            = (state_q == StErr);
`else
    calib_err            = 1'b0;
`endif
    dq_data = dq_in[bit_sel_q];
    dlyinc  = {DQ_WIDTH{dlyinc_in}};
    dlyce   = '0;
    for (int i = 0; i < DQ_WIDTH; i++) begin
      dlyce[i] = dlyce_in && run && (bit_sel_q == DQ_SEL_W'(i));
    end
  end

  // Bit index and one-cycle IDELAY reset pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_sel_q    <= '0;
      idelay_rst_q <= 1'b0;
    end else begin
      idelay_rst_q <= start_run;
      if (start_run || (run && !calib_start)) begin
        bit_sel_q <= '0;
      end else if (advance) begin
        bit_sel_q <= bit_sel_q + DQ_SEL_W'(1);
      end
    end
  end

  // Saturating step for the selected bit's tap count
  always_comb begin
    tap_cur = tap_q[bit_sel_q];
    tap_nxt = tap_cur;
    if (dlyinc_in) begin
      if (tap_cur != 6'd63) tap_nxt = tap_cur + 6'd1;
    end else begin
      if (tap_cur != 6'd0)  tap_nxt = tap_cur - 6'd1;
    end
  end

  // Tap shadow counters; cleared at run start, retained across an abort
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DQ_WIDTH; i++) tap_q[i] <= '0;
    end else if (start_run) begin
      for (int i = 0; i < DQ_WIDTH; i++) tap_q[i] <= '0;
    end else if (run && dlyce_in) begin
      tap_q[bit_sel_q] <= tap_nxt;
    end
  end

  // Flatten tap counters onto the output bus
  always_comb begin
    tap_cnt = '0;
    for (int i = 0; i < DQ_WIDTH; i++) tap_cnt[6*i +: 6] = tap_q[i];
  end

  assign bit_sel    = bit_sel_q;
  assign idelay_rst = idelay_rst_q;

endmodule

// File: tb/tb_ddr2_dq_calib_seq.sv
// Self-checking bench for ddr2_dq_calib_seq: table-driven cycle vectors
// followed by hand-written multi-cycle sequences.
module tb_ddr2_dq_calib_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        calib_start, dlyce_in, dlyinc_in, chan_done_in;
  logic [7:0]  dq_in;
  logic        dq_data, ctrl_dummyread_start, idelay_rst, calib_done, calib_err;
  logic [7:0]  dlyce, dlyinc;
  logic [2:0]  bit_sel;
  logic [47:0] tap_cnt;

  int errors = 0;
  int checks = 0;

  ddr2_dq_calib_seq #(.DQ_WIDTH(8), .DQ_SEL_W(3), .TIMEOUT_W(12)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .calib_start          (calib_start),
    .dq_in                (dq_in),
    .dq_data              (dq_data),
    .ctrl_dummyread_start (ctrl_dummyread_start),
    .dlyce_in             (dlyce_in),
    .dlyinc_in            (dlyinc_in),
    .chan_done_in         (chan_done_in),
    .dlyce                (dlyce),
    .dlyinc               (dlyinc),
    .idelay_rst           (idelay_rst),
    .bit_sel              (bit_sel),
    .tap_cnt              (tap_cnt),
    .calib_done           (calib_done),
    .calib_err            (calib_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the edge.
  task automatic cyc(input logic s, input logic ce, input logic inc, input logic done);
    calib_start  = s;
    dlyce_in     = ce;
    dlyinc_in    = inc;
    chan_done_in = done;
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic        start, ce, inc, done;
    logic [7:0]  dq;
    logic [7:0]  e_ce, e_inc;
    logic        e_dqd;
    logic [2:0]  e_sel;
    logic        e_rd, e_rst, e_done;
    logic [47:0] e_tap;
  } vec_t;

  vec_t vecs [9];
  logic [47:0] exp_tap;

  initial begin
    //            st    ce    inc   done  dq     | e_ce   e_inc  dqd  | sel   rd    rst   done  tap
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 48'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h02, 8'h01, 8'hFF, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 48'h1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 8'hFF, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 48'h2};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 48'h2};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h02, 8'h02, 8'h00, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 48'h2};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hFD, 8'h02, 8'hFF, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 48'h42};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 48'h42};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 48'h42};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 48'h0};

    reset_n = 1'b1; calib_start = 1'b0; dlyce_in = 1'b0; dlyinc_in = 1'b0;
    chan_done_in = 1'b0; dq_in = 8'h00;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_rd",   64'(ctrl_dummyread_start), 64'(1'b0));
    chk("rst_irst", 64'(idelay_rst), 64'(1'b0));
    chk("rst_sel",  64'(bit_sel),    64'(3'd0));
    chk("rst_tap",  64'(tap_cnt),    64'(48'h0));
    chk("rst_done", 64'(calib_done), 64'(1'b0));
    chk("rst_err",  64'(calib_err),  64'(1'b0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven cycle vectors
    for (int i = 0; i < 9; i++) begin
      calib_start  = vecs[i].start;
      dlyce_in     = vecs[i].ce;
      dlyinc_in    = vecs[i].inc;
      chan_done_in = vecs[i].done;
      dq_in        = vecs[i].dq;
      #1;
      chk($sformatf("v%0d_dlyce", i),  64'(dlyce),   64'(vecs[i].e_ce));
      chk($sformatf("v%0d_dlyinc", i), 64'(dlyinc),  64'(vecs[i].e_inc));
      chk($sformatf("v%0d_dqdata", i), 64'(dq_data), 64'(vecs[i].e_dqd));
      @(posedge clk); #1;
      chk($sformatf("v%0d_sel", i),  64'(bit_sel),              64'(vecs[i].e_sel));
      chk($sformatf("v%0d_rd", i),   64'(ctrl_dummyread_start), 64'(vecs[i].e_rd));
      chk($sformatf("v%0d_irst", i), 64'(idelay_rst),           64'(vecs[i].e_rst));
      chk($sformatf("v%0d_done", i), 64'(calib_done),           64'(vecs[i].e_done));
      chk($sformatf("v%0d_tap", i),  64'(tap_cnt),              64'(vecs[i].e_tap));
    end

    // Nominal run: 5 incs then done on each of 8 bits
    restart();
    for (int b = 0; b < 8; b++) begin
      repeat (5) cyc(1'b1, 1'b1, 1'b1, 1'b0);
      chk($sformatf("nom_predone%0d", b), 64'(calib_done), 64'(1'b0));
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      if (b < 7) begin
        chk($sformatf("nom_sel%0d", b), 64'(bit_sel), 64'(b + 1));
      end else begin
        chk("nom_done", 64'(calib_done), 64'(1'b1));
        chk("nom_rd",   64'(ctrl_dummyread_start), 64'(1'b0));
      end
    end
    exp_tap = '0;
    for (int b = 0; b < 8; b++) exp_tap[6*b +: 6] = 6'd5;
    chk("nom_tap", 64'(tap_cnt), 64'(exp_tap));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("nom_hold", 64'(calib_done), 64'(1'b1));
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("nom_clr", 64'(calib_done), 64'(1'b0));

    // Routing: decrement on bit 3 from 10
    restart();
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (10) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rt_tap3_10", 64'(tap_cnt[23:18]), 64'(6'd10));
    calib_start = 1'b1; dlyce_in = 1'b1; dlyinc_in = 1'b0; chan_done_in = 1'b0;
    #1;
    chk("rt_dlyce", 64'(dlyce), 64'(8'h08));
    @(posedge clk); #1;
    chk("rt_tap3_9", 64'(tap_cnt[23:18]), 64'(6'd9));
    chk("rt_tap0",   64'(tap_cnt[5:0]),   64'(6'd0));

    // Saturation at both ends
    restart();
    repeat (70) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("sat_hi", 64'(tap_cnt[5:0]), 64'(6'd63));
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("sat_lo",   64'(tap_cnt[11:6]), 64'(6'd0));
    chk("sat_keep", 64'(tap_cnt[5:0]),  64'(6'd63));

    // Abort coincident with chan_done at bit 4
    restart();
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("ab_sel4", 64'(bit_sel), 64'(3'd4));
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ab_sel",  64'(bit_sel),              64'(3'd0));
    chk("ab_rd",   64'(ctrl_dummyread_start), 64'(1'b0));
    chk("ab_done", 64'(calib_done),           64'(1'b0));
    chk("ab_tap",  64'(tap_cnt),              64'(48'h2));
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ab_idle", 64'(ctrl_dummyread_start), 64'(1'b0));

`ifdef DDR2_CALIB_TIMEOUT_EN
    // Watchdog expiry after 4096 cycles without chan_done
    restart();
    repeat (4095) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("to_pre",  64'(calib_err), 64'(1'b0));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("to_err",  64'(calib_err), 64'(1'b1));
    chk("to_rd",   64'(ctrl_dummyread_start), 64'(1'b0));
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("to_hold", 64'(calib_err), 64'(1'b1));
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("to_clr",  64'(calib_err), 64'(1'b0));
`else
    // No watchdog: still running after 10000 idle cycles
    restart();
    repeat (10000) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("nto_err", 64'(calib_err), 64'(1'b0));
    chk("nto_rd",  64'(ctrl_dummyread_start), 64'(1'b1));
`endif

    // Asynchronous reset mid-run, between clock edges
    restart();
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("ar_pre_sel", 64'(bit_sel), 64'(3'd1));
    chk("ar_pre_tap", 64'(tap_cnt), 64'(48'h3));
    #3 reset_n = 1'b0;
    #1;
    chk("ar_rd",   64'(ctrl_dummyread_start), 64'(1'b0));
    chk("ar_irst", 64'(idelay_rst), 64'(1'b0));
    chk("ar_sel",  64'(bit_sel),    64'(3'd0));
    chk("ar_tap",  64'(tap_cnt),    64'(48'h0));
    chk("ar_done", 64'(calib_done), 64'(1'b0));
    chk("ar_err",  64'(calib_err),  64'(1'b0));
    calib_start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ar_idle", 64'(ctrl_dummyread_start), 64'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr2_dq_calib_seq.md
# ddr2_dq_calib_seq

Per-DQS-group sequencer that drives the per-bit DQ tap calibration controller from the initiator side. It holds the dummy-read request, selects which DQ bit the tap controller sees, routes the controller's IDELAY inc/ce pulses to that bit only, and advances to the next bit on each `chan_done`. It sits between the init/dummy-read logic and the per-bit tap controller, one instance per DQS set. It reports overall completion, timeout error and the resulting per-bit tap values.

## Interface
- `DQ_WIDTH`, 8: DQ bits calibrated by this instance.
- `DQ_SEL_W`, 3: width of the bit index; must equal clog2(`DQ_WIDTH`).
- `TIMEOUT_W`, 12: per-bit watchdog counter width.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `calib_start`  in  1  level; run calibration while high.
- `dq_in`  in  `DQ_WIDTH`  captured DQ (rising-edge IDDR output).
- `dq_data`  out  1  `dq_in[bit_sel]`, combinational; to tap controller.
- `ctrl_dummyread_start`  out  1  registered; high while in RUN.
- `dlyce_in`  in  1  IDELAY ce from tap controller.
- `dlyinc_in`  in  1  IDELAY inc from tap controller.
- `chan_done_in`  in  1  one-cycle per-bit done from tap controller.
- `dlyce`  out  `DQ_WIDTH`  per-bit IDELAY ce.
- `dlyinc`  out  `DQ_WIDTH`  per-bit IDELAY inc.
- `idelay_rst`  out  1  one-cycle IDELAY reset pulse at run start.
- `bit_sel`  out  `DQ_SEL_W`  bit currently being calibrated.
- `tap_cnt`  out  6*`DQ_WIDTH`  tap value per bit; bit i occupies [6i+5:6i].
- `calib_done`  out  1  all bits calibrated.
- `calib_err`  out  1  watchdog expired.

## Operation
- States: IDLE, RUN, DONE, ERR. Reset → IDLE.
- Reset values: `ctrl_dummyread_start`=0, `idelay_rst`=0, `bit_sel`=0, all `tap_cnt`=0, `calib_done`=0, `calib_err`=0, watchdog=0.
- IDLE, `calib_start`=1 → RUN.
  - On that edge: `bit_sel`←0, all `tap_cnt`←0, watchdog←0, `idelay_rst`←1.
  - `idelay_rst` is high for exactly one cycle.
- RUN:
  - `ctrl_dummyread_start`=1.
  - `dlyce[i] = dlyce_in & (bit_sel==i) & RUN`.
  - `dlyinc[i] = dlyinc_in` for every i.
  - `tap_cnt[bit_sel]`: +1 on ce&inc, −1 on ce&!inc, saturating at 63 and 0.
- RUN, `chan_done_in`=1:
  - If `bit_sel`<`DQ_WIDTH`−1: `bit_sel`+1 and watchdog←0.
  - If `bit_sel`=`DQ_WIDTH`−1: → DONE.
- RUN, `calib_start`=0: abort → IDLE. `bit_sel`←0; `tap_cnt` retained; no done or error reported.
- DONE: `calib_done`=1 and `ctrl_dummyread_start`=0. Hold until `calib_start`=0, then → IDLE with `calib_done`←0.
- ERR: `calib_err`=1 and `ctrl_dummyread_start`=0. Exit rule is the same as DONE.
- `chan_done_in`, `dlyce_in` and `dlyinc_in` are ignored outside RUN.
- If `calib_start` falls and `chan_done_in` is high in the same cycle, abort has priority.

## Timing
- All outputs are registered except `dq_data`, `dlyce` and `dlyinc`, which are combinational.
- `calib_start` rising → `ctrl_dummyread_start` high 1 cycle later.
- `chan_done_in` sampled at edge N → new `bit_sel` visible in cycle N+1.
  - This is one cycle before the tap controller re-samples `dq_data` (its DONE→PIPE_WAIT→BIT_CALIBRATION path).
- Last `chan_done_in` at edge N → `calib_done`=1 and `ctrl_dummyread_start`=0 from cycle N+1.
- `tap_cnt` updates on the edge following the ce cycle.
- Asynchronous `reset_n` assertion at any time forces the reset values immediately. The state machine restarts only after deassertion and a high `calib_start`.

## Configuration
- `DDR2_CALIB_TIMEOUT_EN` defined:
  - In RUN, the watchdog increments every cycle.
  - When it reaches all-ones (4095 at default width), the next edge → ERR.
  - In that cycle, `chan_done_in` has priority over the timeout.
- `DDR2_CALIB_TIMEOUT_EN` undefined:
  - No watchdog logic; `calib_err` tied 0; ERR unreachable.

## Test plan
- Nominal run:
  - Stimulus: `calib_start`=1; model tap controller issues 5 inc pulses then `chan_done_in` per bit, 8 bits.
  - Response: `bit_sel` steps 0..7; each `tap_cnt`=5; `calib_done`=1 one cycle after the 8th done; `ctrl_dummyread_start`=0.
- Routing:
  - Stimulus: `bit_sel`=3, `dlyce_in`=1, `dlyinc_in`=0, `tap_cnt[3]`=10.
  - Response: only `dlyce[3]`=1; `tap_cnt[3]`=9 next cycle.
- Saturation:
  - Stimulus: 70 inc pulses on bit 0; separately, 3 dec pulses on bit 1 at 0.
  - Response: `tap_cnt[0]`=63; `tap_cnt[1]`=0.
- Abort:
  - Stimulus: drop `calib_start` while `bit_sel`=4, coincident with `chan_done_in`.
  - Response: IDLE next cycle; `bit_sel`=0; `calib_done`=0; prior `tap_cnt` retained.
- Timeout (macro defined):
  - Stimulus: no `chan_done_in` for 4096 cycles.
  - Response: `calib_err`=1; `ctrl_dummyread_start`=0; `calib_err` clears after `calib_start`=0.
  - Without the macro: no `calib_err` after 10000 cycles.
- Async reset:
  - Stimulus: assert `reset_n`=0 mid-RUN between clock edges.
  - Response: all outputs return to reset values without waiting for a clock edge.
